dft_engine: RTL
===============

# dft_engine

Parametrised fixed-point DFT engine, successor to the 128-point/16-harmonic DFT. It captures an N-sample frame through a valid/ready stream and evaluates its bins in banks of LANES parallel multiply-accumulate lanes. Twiddles come from an external shared sin/cos table addressed with (k·n) mod N. Results go to an internal bin RAM with a random-access read port, and a peak-bin tracker runs alongside. It sits between the sample acquisition front end and the spectrum post-processing logic.

## Interface
- N, 128: frame length; power of two, 8..1024
- LANES, 16: parallel bin lanes; power of two, ≤ N
- DATA_W, 32: signed sample width
- COEF_W, 16: signed twiddle width, Q1.(COEF_W-1); table values symmetric, never −2^(COEF_W-1)
- ACC_W, DATA_W+COEF_W+$clog2(N): signed accumulator/result width
- clk  in  1  clock, all logic on rising edge
- n_reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE
- half_spec  in  1  sampled at start: 1 = bins 0..N/2, 0 = bins 0..N-1
- s_data  in  DATA_W  sample stream, frame order x[0]..x[N-1]
- s_valid  in  1  sample qualifier
- s_ready  out  1  high only in LOAD
- coef_addr  out  LANES×log2N  per-lane table index, lane l in slice l
- cos_in, sin_in  in  LANES×COEF_W  cos/sin of 2π·addr/N, valid one cycle after coef_addr
- rd_addr  in  log2N  result read bin index
- re_out, im_out  out  ACC_W  bin rd_addr, registered, one-cycle read latency
- peak_bin  out  log2N  bin with largest |re|+|im|
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when a frame's results and peak_bin are final

## Operation
- States: IDLE → LOAD (on start) → CALC → DRAIN → (next bank: CALC | last bank: DONE) → IDLE.
- LOAD: each s_valid&&s_ready beat writes s_data to sample buffer [n], n = 0..N-1. After beat N-1, go to CALC. Gaps in s_valid stall LOAD without limit.
- BINS = N/2+1 if half_spec, else N. BANKS = ceil(BINS/LANES). Bank b: lane l computes bin k = b·LANES+l.
- Lanes with k ≥ BINS run but never write the RAM or the tracker.
- CALC: n steps 0..N-1, one per cycle. Lane phase p_l starts at 0 and advances by k mod N each step (log2N-bit wrap, no multiplier). coef_addr = p_l.
- Per lane: re += x[n]·cos, im −= x[n]·sin. Full-precision products are sign-extended to ACC_W. Accumulators wrap with no saturation; the default ACC_W makes overflow impossible. Accumulators clear at n = 0.
- DRAIN: pipeline flush, then bin RAM[k] ← (re, im) for valid lanes. Tracker compares |re|+|im| (ACC_W+1 bits) across lanes. A strictly greater value replaces the current peak, so ties keep the lowest bin.
- DONE: one cycle; done = 1; return to IDLE. The RAM keeps its contents until overwritten by the next frame.
- start is ignored while busy. In half mode, RAM entries above N/2 keep stale values.
- n_reset mid-frame: immediate return to IDLE; the frame is discarded and RAM contents are undefined.

## Timing
- Reset values: s_ready 0, busy 0, done 0, peak_bin 0, coef_addr 0, re_out/im_out 0.
- start in cycle t: LOAD from t+1, s_ready high from t+1.
- CALC pipeline: address (c0), coefficient (c1), product register (c2), accumulate (c3). Each bank occupies N+3 cycles, including DRAIN.
- Last sample accepted at cycle L: done at L + BANKS·(N+3) + 1.
- rd_addr sampled at edge t gives data at t+1. Reads during CALC return the RAM's current contents.

## Structure
- dft_pkg: state enum (IDLE, LOAD, CALC, DRAIN, DONE), CW_N = $clog2(N) helper, abs-sum function.
- Sub-module dft_mac_lane: phase accumulator, product register, re/im accumulators. One instance per lane via generate.
- Top level holds the FSM, sample buffer, bin RAM, bank counter, peak tracker.
- Twiddle table stays external, so it can be shared or replicated per lane.

## Test plan
Common setup: N=16, LANES=4, DATA_W=16, COEF_W=16, table peak 32767.
- DC, all x=1000, full spectrum → bin0 re = 524 272 000, im 0; all other bins 0; peak_bin 0; done 4·19+1 cycles after last beat.
- Impulse x[0]=1000, others 0 → every bin re = 32 767 000, im 0; peak_bin 0 (tie rule).
- Alternating ±1000, half_spec=1 → bin8 re = 524 272 000, others 0; peak_bin 8; 3 banks, lanes 9–11 not written.
- x[n]=1000·sin(2π·3n/16) rounded, table-matched → bin3 im ≈ −8·1000·32767, bin13 mirrored; peak_bin 3.
- Random s_valid gaps (50%) on the DC frame → results identical; s_ready low outside LOAD; start pulsed during CALC is ignored.
- n_reset asserted mid-CALC → all outputs at reset values next cycle; a subsequent frame completes correctly.

Source files
------------

// File: rtl/dft_pkg.sv
// ============================================================================
// Module      : dft_pkg
// Description : Shared types and helpers for the banked fixed-point DFT engine
// Revision    : 1.0
// ============================================================================
`default_nettype none

package dft_pkg;

  // Frame-processing states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CALC  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Working width of the magnitude helper; any ACC_W up to this is supported
  localparam int ABS_W = 128;

  // Index width for an N-entry table
  function automatic int cw_n(input int n);
    return $clog2(n);
  endfunction

  // |a| + |b| evaluated one bit wider than the operands so it cannot wrap
  function automatic logic [ABS_W:0] abs_sum(input logic signed [ABS_W-1:0] a,
                                             input logic signed [ABS_W-1:0] b);
    logic signed [ABS_W:0] ea;
    logic signed [ABS_W:0] eb;
    ea = {a[ABS_W-1], a};
    eb = {b[ABS_W-1], b};
    if (ea < 0) ea = -ea;
    if (eb < 0) eb = -eb;
    return $unsigned(ea) + $unsigned(eb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dft_mac_lane.sv
// ============================================================================
// Module      : dft_mac_lane
// Description : One DFT bin lane: twiddle phase accumulator, registered
//               products and wrapping re/im accumulators
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dft_mac_lane
  import dft_pkg::*;
#(
  parameter  int N      = 128,
  parameter  int DATA_W = 32,
  parameter  int COEF_W = 16,
  parameter  int ACC_W  = DATA_W + COEF_W + $clog2(N),
  localparam int CW     = cw_n(N)
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              step_en_i,
  input  logic [CW-1:0]     k_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [COEF_W-1:0] cos_i,
  input  logic [COEF_W-1:0] sin_i,
  input  logic              acc_en_i,
  input  logic              acc_clr_i,
  output logic [CW-1:0]     phase_o,
  output logic [ACC_W-1:0]  re_o,
  output logic [ACC_W-1:0]  im_o
);

  localparam int PW = DATA_W + COEF_W;

  logic [CW-1:0]           phase_q;
  logic signed [PW-1:0]    prod_re_q;
  logic signed [PW-1:0]    prod_im_q;
  logic signed [ACC_W-1:0] re_q;
  logic signed [ACC_W-1:0] im_q;

  logic signed [PW-1:0]    w_x;
  logic signed [PW-1:0]    w_c;
  logic signed [PW-1:0]    w_s;
  logic signed [ACC_W-1:0] w_pre;
  logic signed [ACC_W-1:0] w_pim;

  assign w_x   = PW'($signed(x_i));
  assign w_c   = PW'($signed(cos_i));
  assign w_s   = PW'($signed(sin_i));
  assign w_pre = ACC_W'(prod_re_q);
  assign w_pim = ACC_W'(prod_im_q);

  // Phase walks by k each step; it returns to zero by itself after N steps
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)       phase_q <= '0;
    else if (step_en_i) phase_q <= phase_q + k_i;
    else                phase_q <= '0;
  end

  // Product stage: sample times the twiddle that arrived from the table
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      prod_re_q <= '0;
      prod_im_q <= '0;
    end else begin
      prod_re_q <= w_x * w_c;
      prod_im_q <= w_x * w_s;
    end
  end

  // Accumulate stage: first term of a bank overwrites, later terms add
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      re_q <= '0;
      im_q <= '0;
    end else if (acc_en_i) begin
      re_q <= acc_clr_i ? w_pre  : re_q + w_pre;
      im_q <= acc_clr_i ? -w_pim : im_q - w_pim;
    end
  end

  assign phase_o = phase_q;
  assign re_o    = re_q;
  assign im_o    = im_q;

endmodule

`default_nettype wire

// File: rtl/dft_engine.sv
// ============================================================================
// Module      : dft_engine
// Description : Banked N-point DFT: sample capture, LANES parallel MAC lanes,
//               bin result RAM with registered read port, peak-bin tracker
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dft_engine
  import dft_pkg::*;
#(
  parameter  int N      = 128,
  parameter  int LANES  = 16,
  parameter  int DATA_W = 32,
  parameter  int COEF_W = 16,
  parameter  int ACC_W  = DATA_W + COEF_W + $clog2(N),
  localparam int CW     = cw_n(N)
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic                    start,
  input  logic                    half_spec,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [LANES*CW-1:0]     coef_addr,
  input  logic [LANES*COEF_W-1:0] cos_in,
  input  logic [LANES*COEF_W-1:0] sin_in,
  input  logic [CW-1:0]           rd_addr,
  output logic [ACC_W-1:0]        re_out,
  output logic [ACC_W-1:0]        im_out,
  output logic [CW-1:0]           peak_bin,
  output logic                    busy,
  output logic                    done
);

  localparam int KW   = CW + 1;
  localparam int LW   = cw_n(LANES);
  localparam int BK_W = cw_n(N / LANES) + 1;
  localparam logic [BK_W-1:0] LAST_FULL = BK_W'(N / LANES - 1);
  localparam logic [BK_W-1:0] LAST_HALF = BK_W'((N / 2 + LANES) / LANES - 1);

  state_e            state_q;
  logic [CW-1:0]     n_q;
  logic [1:0]        dcnt_q;
  logic [BK_W-1:0]   bank_q;
  logic              half_q;
  logic              s_ready_q;
  logic              busy_q;
  logic              done_q;

  logic [DATA_W-1:0] x_c1_q;
  logic              v1_q, f1_q, v2_q, f2_q;

  logic [DATA_W-1:0] sbuf_q   [N];
  logic [ACC_W-1:0]  re_ram_q [N];
  logic [ACC_W-1:0]  im_ram_q [N];
  logic [ACC_W-1:0]  re_out_q;
  logic [ACC_W-1:0]  im_out_q;

  logic [ACC_W:0]    peak_mag_q;
  logic [CW-1:0]     peak_bin_q;
  logic [ABS_W:0]    peak_mag_d;
  logic [CW-1:0]     peak_bin_d;

  logic [KW-1:0]     w_k      [LANES];
  logic              w_lane_wr[LANES];
  logic [ACC_W-1:0]  w_re     [LANES];
  logic [ACC_W-1:0]  w_im     [LANES];
  logic [ABS_W:0]    w_full   [LANES];

  logic              w_beat;
  logic              w_calc;
  logic              w_drain_last;
  logic              w_last_bank;
  logic [KW-1:0]     w_bins;

  assign w_beat       = s_valid & s_ready_q;
  assign w_calc       = (state_q == CALC);
  assign w_drain_last = (state_q == DRAIN) && (dcnt_q == 2'd2);
  assign w_last_bank  = (bank_q == (half_q ? LAST_HALF : LAST_FULL));
  assign w_bins       = half_q ? KW'(N / 2 + 1) : KW'(N);

  // Frame sequencer with registered handshake/status outputs
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      n_q       <= '0;
      dcnt_q    <= '0;
      bank_q    <= '0;
      half_q    <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= LOAD;
            half_q    <= half_spec;
            n_q       <= '0;
            bank_q    <= '0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        LOAD: begin
          if (w_beat) begin
            n_q <= n_q + 1'b1;
            if (n_q == CW'(N - 1)) begin
              state_q   <= CALC;
              s_ready_q <= 1'b0;
            end
          end
        end
        CALC: begin
          n_q <= n_q + 1'b1;
          if (n_q == CW'(N - 1)) begin
            state_q <= DRAIN;
            dcnt_q  <= '0;
          end
        end
        DRAIN: begin
          dcnt_q <= dcnt_q + 1'b1;
          if (dcnt_q == 2'd2) begin
            if (w_last_bank) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= CALC;
              bank_q  <= bank_q + 1'b1;
              n_q     <= '0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sample capture, frame order
  always_ff @(posedge clk) begin
    if ((state_q == LOAD) && w_beat) sbuf_q[n_q] <= s_data;
  end

  // Align the sample and the step markers with the table's one-cycle latency
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      x_c1_q <= '0;
      v1_q   <= 1'b0;
      f1_q   <= 1'b0;
      v2_q   <= 1'b0;
      f2_q   <= 1'b0;
    end else begin
      x_c1_q <= sbuf_q[n_q];
      v1_q   <= w_calc;
      f1_q   <= w_calc && (n_q == '0);
      v2_q   <= v1_q;
      f2_q   <= f1_q;
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign w_k[l]       = (KW'(bank_q) << LW) + KW'(l);
      assign w_lane_wr[l] = (w_k[l] < w_bins);
      assign w_full[l]    = abs_sum(ABS_W'($signed(w_re[l])), ABS_W'($signed(w_im[l])));

      dft_mac_lane #(
        .N      (N),
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
      ) u_lane (
        .clk       (clk),
        .n_reset   (n_reset),
        .step_en_i (w_calc),
        .k_i       (w_k[l][CW-1:0]),
        .x_i       (x_c1_q),
        .cos_i     (cos_in[l*COEF_W +: COEF_W]),
        .sin_i     (sin_in[l*COEF_W +: COEF_W]),
        .acc_en_i  (v2_q),
        .acc_clr_i (f2_q),
        .phase_o   (coef_addr[l*CW +: CW]),
        .re_o      (w_re[l]),
        .im_o      (w_im[l])
      );
    end
  endgenerate

  // Peak search over the bank: lanes scanned low to high, strict compare
  always_comb begin
    peak_mag_d = {{(ABS_W - ACC_W){1'b0}}, peak_mag_q};
    peak_bin_d = peak_bin_q;
    for (int l = 0; l < LANES; l++) begin
      if (w_lane_wr[l] && (w_full[l] > peak_mag_d)) begin
        peak_mag_d = w_full[l];
        peak_bin_d = w_k[l][CW-1:0];
      end
    end
  end

  // Peak tracker: cleared when a frame is accepted, updated once per bank
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      peak_mag_q <= '0;
      peak_bin_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      peak_mag_q <= '0;
      peak_bin_q <= '0;
    end else if (w_drain_last) begin
      peak_mag_q <= peak_mag_d[ACC_W:0];
      peak_bin_q <= peak_bin_d;
    end
  end

  // Bin RAM write: only lanes whose bin lies inside the requested spectrum
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (w_drain_last && w_lane_wr[l]) begin
        re_ram_q[w_k[l][CW-1:0]] <= w_re[l];
        im_ram_q[w_k[l][CW-1:0]] <= w_im[l];
      end
    end
  end

  // Registered random-access read port
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      re_out_q <= '0;
      im_out_q <= '0;
    end else begin
      re_out_q <= re_ram_q[rd_addr];
      im_out_q <= im_ram_q[rd_addr];
    end
  end

  assign s_ready  = s_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign peak_bin = peak_bin_q;
  assign re_out   = re_out_q;
  assign im_out   = im_out_q;

endmodule

`default_nettype wire
